// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-requester ALU sharing arbiter.
// Combinational constants only; no latency.
// No flow control of its own.
package alu_share_pkg;

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Bit positions inside the 3-bit response flag vector {ovf, cout, zero}
    localparam int FLAG_ZERO = 0;
    localparam int FLAG_COUT = 1;
    localparam int FLAG_OVF  = 2;

    // ALU_control encodings understood by the shared ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Two-way round-robin arbiter with a registered last-grant pointer.
// Grant is combinational (zero latency); pointer updates on the grant edge.
// Grant is forced to zero while enable is low.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       last_gnt
);

    logic last_q;
    logic last_d;

    // Pick the lone requester, or the one not served last when both ask
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Pointer only moves when a grant is actually issued
    always_comb begin
        last_d = last_q;
        if (grant != 2'b00) begin
            last_d = grant[1];
        end
    end

    // Reset value 1 means "requester 1 was served last", so req0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_gnt = last_q;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two valid/ready requesters, round-robin, one op in flight.
// Accept -> response valid in 2 edges; at most one op per 3 cycles.
// Requests are held off (ready low) until the current response is consumed.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 4,
    parameter int BONUS_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_src1,
    input  logic [DATA_W-1:0]  req0_src2,
    input  logic [CTRL_W-1:0]  req0_ctrl,
    input  logic [BONUS_W-1:0] req0_bonus,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_src1,
    input  logic [DATA_W-1:0]  req1_src2,
    input  logic [CTRL_W-1:0]  req1_ctrl,
    input  logic [BONUS_W-1:0] req1_bonus,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [DATA_W-1:0]  rsp0_result,
    output logic [2:0]         rsp0_flags,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [DATA_W-1:0]  rsp1_result,
    output logic [2:0]         rsp1_flags,
    output logic               alu_rst_n,
    output logic [DATA_W-1:0]  alu_src1,
    output logic [DATA_W-1:0]  alu_src2,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic [BONUS_W-1:0] alu_bonus,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_zero,
    input  logic               alu_cout,
    input  logic               alu_overflow
);

    logic [1:0]               state_q, state_d;
    logic                     gnt_id_q, gnt_id_d;
    logic [DATA_W-1:0]        src1_q, src1_d;
    logic [DATA_W-1:0]        src2_q, src2_d;
    logic [CTRL_W-1:0]        ctrl_q, ctrl_d;
    logic [BONUS_W-1:0]       bonus_q, bonus_d;
    logic [1:0]               rsp_valid_q, rsp_valid_d;
    logic [1:0][DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic [1:0][2:0]          rsp_flags_q, rsp_flags_d;
    logic                     alu_rst_n_q, alu_rst_n_d;

    logic [1:0]               grant;
    logic                     last_gnt;
    logic                     arb_en;
    logic [2:0]               alu_flags;
    logic [1:0]               rsp_rdy;

    // New grants are only considered while no operation is in flight
    assign arb_en  = (state_q == ST_IDLE);
    assign rsp_rdy = {rsp1_ready, rsp0_ready};

    rr_arbiter_2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      ({req1_valid, req0_valid}),
        .enable   (arb_en),
        .grant    (grant),
        .last_gnt (last_gnt)
    );

    // Gather ALU status bits into the response flag layout
    always_comb begin
        alu_flags            = 3'b000;
        alu_flags[FLAG_ZERO] = alu_zero;
        alu_flags[FLAG_COUT] = alu_cout;
        alu_flags[FLAG_OVF]  = alu_overflow;
    end

    // IDLE latches the granted request, EXEC captures the ALU, RESP waits for the consumer
    always_comb begin
        state_d      = state_q;
        gnt_id_d     = gnt_id_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        ctrl_d       = ctrl_q;
        bonus_d      = bonus_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        alu_rst_n_d  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    gnt_id_d = grant[1];
                    src1_d   = grant[1] ? req1_src1  : req0_src1;
                    src2_d   = grant[1] ? req1_src2  : req0_src2;
                    ctrl_d   = grant[1] ? req1_ctrl  : req0_ctrl;
                    bonus_d  = grant[1] ? req1_bonus : req0_bonus;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_result_d[gnt_id_q] = alu_result;
                rsp_flags_d[gnt_id_q]  = alu_flags;
                rsp_valid_d[gnt_id_q]  = 1'b1;
                state_d                = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_valid_q[gnt_id_q] && rsp_rdy[gnt_id_q]) begin
                    rsp_valid_d[gnt_id_q] = 1'b0;
                    state_d               = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight work
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gnt_id_q     <= 1'b0;
            src1_q       <= '0;
            src2_q       <= '0;
            ctrl_q       <= '0;
            bonus_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            alu_rst_n_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_id_q     <= gnt_id_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            ctrl_q       <= ctrl_d;
            bonus_q      <= bonus_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            alu_rst_n_q  <= alu_rst_n_d;
        end
    end

    assign req0_ready  = grant[0];
    assign req1_ready  = grant[1];
    assign rsp0_valid  = rsp_valid_q[0];
    assign rsp1_valid  = rsp_valid_q[1];
    assign rsp0_result = rsp_result_q[0];
    assign rsp1_result = rsp_result_q[1];
    assign rsp0_flags  = rsp_flags_q[0];
    assign rsp1_flags  = rsp_flags_q[1];
    assign alu_rst_n   = alu_rst_n_q;
    assign alu_src1    = src1_q;
    assign alu_src2    = src2_q;
    assign alu_ctrl    = ctrl_q;
    assign alu_bonus   = bonus_q;

    // The pointer is kept for observability only
    logic unused_last;
    assign unused_last = last_gnt;

endmodule
